// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-locked sharing of one 8N1 serial TX line
//               with host flow control. Optional lock timeout is enabled by
//               defining UART_TX_ARBITER_LOCK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int CLK_RATE     = 24000000,
    parameter int BAUD_RATE    = 1200,
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    input  logic               ser_rtsn,
    output logic               ser_tx,
    output logic               busy
);

    localparam int c_DIV   = CLK_RATE / BAUD_RATE;
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(c_DIV - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    generate
        if (c_DIV < 2 || N_REQ < 1 || N_REQ > 8 || LOCK_TIMEOUT < 1) begin : g_param_check
            $error("uart_tx_arbiter: illegal parameters (DIV must be >= 2, N_REQ 1..8, LOCK_TIMEOUT >= 1)");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_div_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_last;
    logic               r_tx;
    logic               r_locked;
    logic [c_IDX_W-1:0] r_owner;
    logic [c_IDX_W-1:0] r_rr;

    logic [c_IDX_W-1:0] w_cand;
    logic               w_cand_vld;
    logic [7:0]         w_cand_data;
    logic               w_cand_last;
    logic               w_accept;
    logic               w_div_done;
    logic               w_to_expire;
    int                 w_idx;

    // Locked: owner only. Unlocked: first valid after rr, wrapping.
    always_comb begin
        w_cand     = r_owner;
        w_cand_vld = 1'b0;
        w_idx      = 0;
        if (r_locked) begin
            w_cand_vld = req_valid[r_owner];
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                w_idx = int'(r_rr) + k;
                if (w_idx >= N_REQ) begin
                    w_idx = w_idx - N_REQ;
                end
                if (req_valid[c_IDX_W'(w_idx)]) begin
                    w_cand     = c_IDX_W'(w_idx);
                    w_cand_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cand_data = 8'h00;
        w_cand_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_cand == c_IDX_W'(i)) begin
                w_cand_data = req_data[8*i +: 8];
                w_cand_last = req_last[i];
            end
        end
    end

    assign w_accept   = (r_state == c_ST_IDLE) && w_cand_vld && !ser_rtsn && !reset;
    assign w_div_done = (r_div_cnt == c_DIV_LAST);
    assign req_ready  = w_accept ? (N_REQ'(1) << w_cand) : '0;
    assign grant      = r_locked ? (N_REQ'(1) << r_owner) : '0;
    assign busy       = (r_state != c_ST_IDLE);
    assign ser_tx     = r_tx;

`ifdef UART_TX_ARBITER_LOCK_TIMEOUT_EN
    localparam int c_TO_W = $clog2(LOCK_TIMEOUT + 1);
    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_to_idle;

    assign w_to_idle   = (r_state == c_ST_IDLE) && r_locked && !req_valid[r_owner];
    assign w_to_expire = w_to_idle && (r_to_cnt == c_TO_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (reset || w_accept || !w_to_idle || w_to_expire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end
`else
    assign w_to_expire = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_nxt = c_ST_START;
            c_ST_START: if (w_div_done) w_state_nxt = c_ST_DATA;
            c_ST_DATA:  if (w_div_done && r_bit_cnt == 3'd7) w_state_nxt = c_ST_STOP;
            c_ST_STOP:  if (w_div_done) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ser_tx is registered so the pin never glitches on state changes.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_last    <= 1'b0;
            r_tx      <= 1'b1;
            r_locked  <= 1'b0;
            r_owner   <= '0;
            r_rr      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= 3'd0;
                    if (w_accept) begin
                        r_shift  <= w_cand_data;
                        r_last   <= w_cand_last;
                        r_locked <= 1'b1;
                        r_owner  <= w_cand;
                        r_rr     <= w_cand;
                        r_tx     <= 1'b0;
                    end else if (w_to_expire) begin
                        r_locked <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_div_cnt <= r_div_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_DATA: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_shift   <= r_shift >> 1;
                        r_tx      <= (r_bit_cnt == 3'd7) ? 1'b1 : r_shift[1];
                    end else begin
                        r_div_cnt <= r_div_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        if (r_last) begin
                            r_locked <= 1'b0;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter (DIV = 16).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        CLK;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        ser_rtsn;
    logic        ser_tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_tx_arbiter #(
        .N_REQ        (2),
        .CLK_RATE     (16),
        .BAUD_RATE    (1),
        .LOCK_TIMEOUT (8)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .ser_rtsn  (ser_rtsn),
        .ser_tx    (ser_tx),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered one cycle after the accept edge; returns on the first IDLE cycle.
    task automatic run_frame(input string tag, input logic [7:0] b, input logic [1:0] g,
                             input int rtsn_at);
        int   bad_tx    = 0;
        int   bad_busy  = 0;
        int   bad_grant = 0;
        int   bad_ready = 0;
        logic e;
        for (int c = 0; c < 160; c++) begin
            if (c < 16)       e = 1'b0;
            else if (c < 144) e = b[(c - 16) >> 4];
            else              e = 1'b1;
            if (ser_tx !== e)        bad_tx++;
            if (busy !== 1'b1)       bad_busy++;
            if (grant !== g)         bad_grant++;
            if (req_ready !== 2'b00) bad_ready++;
            if (c == rtsn_at) ser_rtsn = 1'b1;
            tick();
        end
        chk({tag, " ser_tx bad cycles"}, bad_tx, 0);
        chk({tag, " busy bad cycles"}, bad_busy, 0);
        chk({tag, " grant bad cycles"}, bad_grant, 0);
        chk({tag, " ready in frame"}, bad_ready, 0);
        chk({tag, " busy after frame"}, busy, 1'b0);
    endtask

    initial begin
        int start_cyc [4];
        int bad;

        reset     = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        req_last  = 2'b00;
        ser_rtsn  = 1'b0;
        tick(); tick(); tick();
        chk("reset ser_tx", ser_tx, 1'b1);
        chk("reset ready", req_ready, 2'b00);
        chk("reset grant", grant, 2'b00);
        chk("reset busy", busy, 1'b0);
        reset = 1'b0;
        tick();

        // Single byte 0xA5 from req0
        req_valid = 2'b01; req_data = 16'h00A5; req_last = 2'b01;
        #1 chk("single ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        run_frame("single A5", 8'hA5, 2'b01, -1);
        chk("single grant after", grant, 2'b00);
        chk("single ser_tx after", ser_tx, 1'b1);

        // Packet lock: req0 0x11,0x22 while req1 holds 0x33
        req_valid = 2'b01; req_data = 16'h0011; req_last = 2'b00;
        #1 chk("lock ready 11", req_ready, 2'b01);
        tick();
        req_valid = 2'b11; req_data = 16'h3322; req_last = 2'b11;
        run_frame("lock 11", 8'h11, 2'b01, -1);
        chk("lock ready 22", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        run_frame("lock 22", 8'h22, 2'b01, -1);
        chk("lock grant released", grant, 2'b00);
        chk("lock ready 33", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        run_frame("lock 33", 8'h33, 2'b10, -1);

        // Round-robin with both requesters continuously valid
        req_valid = 2'b11; req_data = 16'h3CC3; req_last = 2'b11;
        for (int f = 0; f < 4; f++) begin
            #1 chk("rr ready", req_ready, (f % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            start_cyc[f] = cyc;
            run_frame("rr frame", (f % 2 == 0) ? 8'hC3 : 8'h3C,
                      (f % 2 == 0) ? 2'b01 : 2'b10, -1);
        end
        req_valid = 2'b00;
        for (int f = 1; f < 4; f++) begin
            chk("rr spacing", start_cyc[f] - start_cyc[f-1], 161);
        end

        // Flow control held from reset
        reset = 1'b1; ser_rtsn = 1'b1;
        req_valid = 2'b01; req_data = 16'h005A; req_last = 2'b01;
        tick(); tick();
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            if (req_ready !== 2'b00 || ser_tx !== 1'b1 || busy !== 1'b0) bad++;
            tick();
        end
        chk("rtsn hold bad cycles", bad, 0);
        ser_rtsn = 1'b0;
        #1 chk("rtsn release ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        run_frame("rtsn 5A", 8'h5A, 2'b01, -1);

        // rtsn raised at bit 3 of a frame
        req_valid = 2'b01; req_data = 16'h0096; req_last = 2'b01;
        #1 chk("midrts ready", req_ready, 2'b01);
        tick();
        req_data = 16'h0069;
        run_frame("midrts 96", 8'h96, 2'b01, 64);
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            if (req_ready !== 2'b00 || ser_tx !== 1'b1 || busy !== 1'b0) bad++;
            tick();
        end
        chk("midrts blocked bad cycles", bad, 0);
        ser_rtsn = 1'b0;
        #1 chk("midrts resume ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        run_frame("midrts 69", 8'h69, 2'b01, -1);

        // Reset at cycle 50 of a 0xFF frame
        req_valid = 2'b01; req_data = 16'h00FF; req_last = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int c = 0; c < 50; c++) tick();
        chk("abort busy before", busy, 1'b1);
        chk("abort grant before", grant, 2'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort ser_tx", ser_tx, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort grant", grant, 2'b00);
        req_valid = 2'b01; req_data = 16'h0000; req_last = 2'b01;
        tick();
        req_valid = 2'b00;
        run_frame("abort 00", 8'h00, 2'b01, -1);

        // Owner abandons an open packet
        req_valid = 2'b01; req_data = 16'h0001; req_last = 2'b00;
        #1 chk("to ready 01", req_ready, 2'b01);
        tick();
        req_valid = 2'b10; req_data = 16'h7700; req_last = 2'b10;
        run_frame("to 01", 8'h01, 2'b01, -1);
`ifdef UART_TX_ARBITER_LOCK_TIMEOUT_EN
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (grant !== 2'b01 || req_ready !== 2'b00) bad++;
            tick();
        end
        chk("to held bad cycles", bad, 0);
        chk("to grant cleared", grant, 2'b00);
        chk("to ready req1", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        run_frame("to 77", 8'h77, 2'b10, -1);
`else
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            if (req_ready[1] !== 1'b0 || ser_tx !== 1'b1 || grant !== 2'b01) bad++;
            tick();
        end
        chk("starve bad cycles", bad, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single board serial TX line (SER_TX) between N_REQ on-chip requesters: round-robin byte-stream arbitration with packet lock, 8N1 serializer and host flow control.
- Sits between SoC-side producers (console, debug dump, etc.) and the SER_TX/SER_RTSn pins of the iCE40 top.
- Clocked by the PLL clock; reset is driven from PLL lock loss.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- CLK_RATE, 24000000, clock frequency in Hz.
- BAUD_RATE, 1200, serial bit rate in Hz.
- DIV = CLK_RATE/BAUD_RATE (derived localparam, integer divide), clocks per bit. Must be >= 2; elaboration error otherwise.
- LOCK_TIMEOUT, 256, idle-cycle limit for packet lock (used only with the optional feature).

Ports:
- CLK  in  1  system clock (single clock domain).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  byte is the last of the requester's packet.
- req_ready  out  N_REQ  one-hot byte-accept strobe.
- grant  out  N_REQ  one-hot owner of the current packet lock; 0 when unlocked.
- ser_rtsn  in  1  host flow control; low = host may receive. Synchronise externally.
- ser_tx  out  1  serial line; idle high.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset values: ser_tx=1, req_ready=0, grant=0, busy=0, state=IDLE, rr pointer=0, lock cleared, bit/divider counters 0.
- Reset is sampled at the clock edge. Reset asserted mid-frame aborts the frame; ser_tx=1 from the next edge.
- States: IDLE, START, DATA, STOP.
- IDLE, candidate selection:
  - If locked, the only candidate is the lock owner.
  - Otherwise, the first i with req_valid[i]=1, searching round-robin from rr+1 (wrapping mod N_REQ).
- IDLE, accept:
  - Accept only when a candidate exists and ser_rtsn=0.
  - req_ready[cand] is combinational and high in that cycle; transfer = valid & ready.
  - On accept: latch data and last, set lock to the candidate, set rr=cand, go to START.
  - grant reflects the registered lock owner.
- START: ser_tx=0 for DIV cycles.
- DATA: 8 bits LSB first, each held DIV cycles.
- STOP: ser_tx=1 for DIV cycles, then IDLE.
  - If the latched last=1, the lock clears when STOP ends.
- Timing:
  - Frame = 10*DIV cycles.
  - ser_tx falls on the first cycle after the accept edge.
  - Minimum inter-frame gap is 1 clock (one IDLE cycle).
  - req_ready is never high outside IDLE.
- Flow control: ser_rtsn high mid-frame has no effect; the frame completes. It only blocks the next accept and does not release the lock.
- Locked owner drops req_valid: lock is held indefinitely and other requesters starve (base build).
- Arbitration fairness:
  - Simultaneous valids on an unlocked cycle: lowest index after rr wins.
  - After rr=N_REQ-1, the search starts at 0.
  - N_REQ=1: rr logic collapses and the requester always wins.
- Divider counter width is $clog2(DIV); bit counter is 3 bits. No multiplies or divides in the datapath.

Optional Feature:
- Macro: UART_TX_ARBITER_LOCK_TIMEOUT_EN.
- Defined:
  - Counter counts consecutive IDLE cycles while locked with the owner's req_valid=0.
  - Reaching LOCK_TIMEOUT clears the lock (grant goes 0 next cycle) and normal round-robin resumes; rr is unchanged.
  - The counter resets on any accept or on reset.
- Undefined: no counter; lock held until a last byte completes.

Test Plan:
- Bench parameters for all scenarios: CLK_RATE=16, BAUD_RATE=1, so DIV=16.
- Single byte: N_REQ=2, req0 sends 0xA5 with last=1, rtsn=0.
  - req_ready[0] pulses once.
  - ser_tx = 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles.
  - busy high for 160 cycles; grant 01 during the frame, 00 afterwards.
- Packet lock: req0 sends 0x11 (last=0), 0x22 (last=1) while req1 holds 0x33 valid continuously.
  - Wire order is 0x11, 0x22, 0x33.
  - grant = 01 through byte 2, then 10; req_ready[1] stays low until after the 0x22 STOP.
- Round-robin: both requesters present single-byte packets (last=1) continuously for 4 frames.
  - Grant order is 0,1,0,1.
  - ser_tx start edges are spaced 161 cycles apart.
- Flow control:
  - rtsn=1 at reset with req0 valid: no req_ready and ser_tx=1 for 500 cycles; drop rtsn and the frame starts on the next cycle.
  - Raising rtsn at bit 3 of a frame: that frame still ends at 160 cycles, and no new start occurs while rtsn=1.
- Reset mid-frame: assert reset at cycle 50 of a 0xFF frame for 1 cycle.
  - ser_tx=1, busy=0, grant=0 from the next edge.
  - A new 0x00 byte then transmits a correct frame.
- Timeout (macro defined, LOCK_TIMEOUT=8):
  - req0 sends 0x01 with last=0 then drops valid; req1 is valid.
  - grant clears 8 cycles after the STOP ends, and req1's byte follows.
  - With the macro undefined, req1 never transmits within 1000 cycles.
